// File: rtl/burst_read_scheduler.sv
// burst_read_scheduler: arbitrates two video-line read channels onto a single
// burst command port, one burst outstanding at a time. Each channel walks its
// frame buffer line by line and wraps to its base after the last line.
module burst_read_scheduler #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] CH0_BASE   = ADDR_WIDTH'(32'h0000_0000),
    parameter logic [ADDR_WIDTH-1:0] CH1_BASE   = ADDR_WIDTH'(32'h0080_0000),
    parameter int                    LINE_BYTES = 7680,
    parameter int                    V_DISP     = 1080
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESET,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_frame_start,
    output logic [1:0]            req_ready,
    output logic                  burst_valid,
    input  logic                  burst_ready,
    output logic [ADDR_WIDTH-1:0] burst_addr,
    output logic                  burst_ch,
    input  logic                  burst_done,
    output logic [1:0]            frame_done,
    output logic                  busy
);

    localparam int CNT_W = (V_DISP > 1) ? $clog2(V_DISP) : 1;
    localparam logic [CNT_W-1:0]      LAST_LINE = CNT_W'(V_DISP - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_INC  = ADDR_WIDTH'(LINE_BYTES);
    localparam logic [1:0][ADDR_WIDTH-1:0] BASE = {CH1_BASE, CH0_BASE};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic                        last_grant_q, last_grant_d;
    logic                        burst_valid_q, burst_valid_d;
    logic [ADDR_WIDTH-1:0]       burst_addr_q, burst_addr_d;
    logic                        burst_ch_q, burst_ch_d;
    logic [1:0]                  frame_done_q, frame_done_d;
    logic [1:0][ADDR_WIDTH-1:0]  next_addr_q, next_addr_d;
    logic [1:0][CNT_W-1:0]       line_cnt_q, line_cnt_d;

    logic grant_ch;
    logic accept;

    // Round-robin grant; req_ready is only offered while idle and out of reset
    always_comb begin
        grant_ch = 1'b0;
        case (req_valid)
            2'b01:   grant_ch = 1'b0;
            2'b10:   grant_ch = 1'b1;
            2'b11:   grant_ch = ~last_grant_q;
            default: grant_ch = 1'b0;
        endcase
        req_ready = 2'b00;
        if (state_q == ST_IDLE && !M_AXI_ARESET && (|req_valid))
            req_ready[grant_ch] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);

    // Next-state, command and per-channel line walker
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        burst_valid_d = burst_valid_q;
        burst_addr_d  = burst_addr_q;
        burst_ch_d    = burst_ch_q;
        frame_done_d  = 2'b00;
        next_addr_d   = next_addr_q;
        line_cnt_d    = line_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d       = ST_ISSUE;
                    burst_valid_d = 1'b1;
                    burst_ch_d    = grant_ch;
                    if (req_frame_start[grant_ch]) begin
                        // Frame start resynchronises the walker to line 0
                        burst_addr_d          = BASE[grant_ch];
                        next_addr_d[grant_ch] = BASE[grant_ch] + LINE_INC;
                        line_cnt_d[grant_ch]  = CNT_W'(1);
                    end else if (line_cnt_q[grant_ch] == LAST_LINE) begin
                        // Last line of the frame: wrap for the next frame
                        burst_addr_d           = next_addr_q[grant_ch];
                        next_addr_d[grant_ch]  = BASE[grant_ch];
                        line_cnt_d[grant_ch]   = '0;
                        frame_done_d[grant_ch] = 1'b1;
                    end else begin
                        burst_addr_d          = next_addr_q[grant_ch];
                        next_addr_d[grant_ch] = next_addr_q[grant_ch] + LINE_INC;
                        line_cnt_d[grant_ch]  = line_cnt_q[grant_ch] + CNT_W'(1);
                    end
                end
            end
            ST_ISSUE: begin
                if (burst_ready) begin
                    state_d       = ST_WAIT;
                    burst_valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (burst_done) begin
                    state_d      = ST_IDLE;
                    last_grant_d = burst_ch_q;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                burst_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset abandons any burst in flight
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            burst_valid_q <= 1'b0;
            burst_addr_q  <= '0;
            burst_ch_q    <= 1'b0;
            frame_done_q  <= 2'b00;
            next_addr_q   <= BASE;
            line_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            burst_valid_q <= burst_valid_d;
            burst_addr_q  <= burst_addr_d;
            burst_ch_q    <= burst_ch_d;
            frame_done_q  <= frame_done_d;
            next_addr_q   <= next_addr_d;
            line_cnt_q    <= line_cnt_d;
        end
    end

    assign burst_valid = burst_valid_q;
    assign burst_addr  = burst_addr_q;
    assign burst_ch    = burst_ch_q;
    assign frame_done  = frame_done_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_burst_read_scheduler.sv
// Bench for burst_read_scheduler: directed requests, expected bursts queued by
// the stimulus and checked by a monitor whenever a burst handshake occurs.
module tb_burst_read_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_frame_start = 2'b00;
    logic [1:0]  req_ready;
    logic        burst_valid;
    logic        burst_ready = 1'b1;
    logic [31:0] burst_addr;
    logic        burst_ch;
    logic        burst_done;
    logic [1:0]  frame_done;
    logic        busy;

    logic auto_pulse = 1'b0;
    logic force_done = 1'b0;
    bit   auto_done  = 1'b1;
    assign burst_done = auto_pulse | force_done;

    typedef struct {
        logic [31:0] addr;
        logic        ch;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int fd0_cnt = 0;
    int fd1_cnt = 0;

    localparam logic [31:0] CH1 = 32'h0080_0000;

    burst_read_scheduler dut (
        .M_AXI_ACLK      (clk),
        .M_AXI_ARESET    (rst),
        .req_valid       (req_valid),
        .req_frame_start (req_frame_start),
        .req_ready       (req_ready),
        .burst_valid     (burst_valid),
        .burst_ready     (burst_ready),
        .burst_addr      (burst_addr),
        .burst_ch        (burst_ch),
        .burst_done      (burst_done),
        .frame_done      (frame_done),
        .busy            (busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Pops one expected burst per command handshake
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                fd0_cnt += int'(frame_done[0]);
                fd1_cnt += int'(frame_done[1]);
                if (burst_valid && burst_ready) begin
                    if (exp_q.size() == 0) begin
                        check("burst_unexpected", {32'h0, burst_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("burst_addr", {32'h0, burst_addr}, {32'h0, e.addr});
                        check("burst_ch", {63'h0, burst_ch}, {63'h0, e.ch});
                    end
                end
            end
        end
    endtask

    // Read-master model: pulses burst_done two cycles after each command
    task automatic responder();
        int timer = 0;
        bit hs;
        forever begin
            @(posedge clk);
            hs = burst_valid && burst_ready && !rst;
            #1;
            auto_pulse = 1'b0;
            if (rst) timer = 0;
            else begin
                if (timer > 0) begin
                    timer--;
                    if (timer == 0) auto_pulse = 1'b1;
                end
                if (hs && auto_done) timer = 1;
            end
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic c);
        exp_t e;
        e.addr = a;
        e.ch   = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(name, {63'h0, busy}, 64'h0);
    endtask

    task automatic wait_ready(input logic [1:0] mask);
        int t = 0;
        @(negedge clk);
        while (((req_ready & mask) == 2'b00) && t < 50) begin
            @(negedge clk);
            t++;
        end
    endtask

    // One complete request on channel ch through to burst_done
    task automatic do_req(input int ch, input bit fsv, input logic [31:0] ea,
                          output logic [1:0] fd_seen);
        logic [1:0] onehot;
        onehot = (ch == 0) ? 2'b01 : 2'b10;
        push_exp(ea, onehot[1]);
        @(posedge clk); #1;
        req_valid       = onehot;
        req_frame_start = fsv ? onehot : 2'b00;
        wait_ready(onehot);
        check("req_grant", {62'h0, req_ready}, {62'h0, onehot});
        @(posedge clk); #1;
        req_valid       = 2'b00;
        req_frame_start = 2'b00;
        @(negedge clk);
        check("post_accept", {60'h0, req_ready, busy, burst_valid}, {60'h0, 2'b00, 1'b1, 1'b1});
        fd_seen = frame_done;
        wait_idle("burst_complete");
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 2'b00;
        req_frame_start = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] fd;
        logic [1:0] exp_rdy;
        int fd_base;

        fork
            monitor();
            responder();
        join_none

        // Reset state with a request pending
        req_valid = 2'b01;
        req_frame_start = 2'b01;
        repeat (3) @(negedge clk);
        check("reset_req_ready", {62'h0, req_ready}, 64'h0);
        check("reset_outputs", {burst_valid, burst_addr, burst_ch, frame_done, busy}, 64'h0);
        req_valid = 2'b00;
        req_frame_start = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        // Frame start then next line on channel 0
        do_req(0, 1'b1, 32'h0000_0000, fd);
        do_req(0, 1'b0, 32'h0000_1E00, fd);

        // Both channels held: grants alternate starting with channel 0
        do_reset();
        push_exp(32'h0000_0000, 1'b0);
        push_exp(CH1,           1'b1);
        push_exp(32'h0000_1E00, 1'b0);
        push_exp(CH1 + 32'h1E00, 1'b1);
        @(posedge clk); #1;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ready(2'b11);
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            check("rr_grant", {62'h0, req_ready}, {62'h0, exp_rdy});
            @(posedge clk);
        end
        #1;
        req_valid = 2'b00;
        wait_idle("rr_complete");

        // Full frame on channel 1 with wrap
        do_reset();
        fd_base = fd1_cnt;
        for (int i = 0; i < 1080; i++) begin
            do_req(1, (i == 0), CH1 + 32'(i) * 32'd7680, fd);
            if (i == 1079) check("frame_done_pulse", {62'h0, fd}, {62'h0, 2'b10});
        end
        check("frame_done_count", 64'(fd1_cnt - fd_base), 64'd1);
        check("frame_done_ch0", 64'(fd0_cnt), 64'd0);
        do_req(1, 1'b0, CH1, fd);

        // Command stalled by burst_ready low for 10 cycles
        push_exp(CH1, 1'b1);
        @(posedge clk); #1;
        burst_ready = 1'b0;
        req_valid = 2'b10;
        req_frame_start = 2'b10;
        wait_ready(2'b10);
        check("stall_grant", {62'h0, req_ready}, {62'h0, 2'b10});
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_frame_start = 2'b00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold", {27'h0, burst_valid, burst_addr, burst_ch, req_ready, busy},
                  {27'h0, 1'b1, CH1, 1'b1, 2'b00, 1'b1});
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        burst_ready = 1'b1;
        wait_idle("stall_complete");

        // burst_done during ISSUE is ignored; a fresh one is needed in WAIT_DONE
        auto_done = 1'b0;
        push_exp(CH1 + 32'h1E00, 1'b1);
        @(posedge clk); #1;
        burst_ready = 1'b0;
        req_valid = 2'b10;
        wait_ready(2'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        force_done = 1'b1;
        @(posedge clk); #1;
        force_done = 1'b0;
        @(negedge clk);
        check("issue_done_ignored", {62'h0, burst_valid, busy}, {62'h0, 2'b11});
        @(posedge clk); #1;
        burst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) check("wait_done_hold", {62'h0, burst_valid, busy}, {62'h0, 2'b01});
        end
        @(posedge clk); #1;
        force_done = 1'b1;
        @(posedge clk); #1;
        force_done = 1'b0;
        @(negedge clk);
        check("wait_done_release", {63'h0, busy}, 64'h0);

        // Reset during WAIT_DONE, stray burst_done in IDLE, walker back at base
        push_exp(32'h0000_0000, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_frame_start = 2'b01;
        wait_ready(2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_frame_start = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        check("in_wait_done", {62'h0, burst_valid, busy}, {62'h0, 2'b01});
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset", {60'h0, req_ready, burst_valid, busy}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        force_done = 1'b1;
        @(posedge clk); #1;
        force_done = 1'b0;
        @(negedge clk);
        check("stray_done_idle", {62'h0, burst_valid, busy}, 64'h0);
        auto_done = 1'b1;
        do_req(0, 1'b0, 32'h0000_0000, fd);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_read_scheduler.md
BURST_READ_SCHEDULER -- requirements
Module: burst_read_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default 32; DDR byte-address width.
REQ-002 Parameter CH0_BASE, default 32'h0000_0000; frame base address, channel 0.
REQ-003 Parameter CH1_BASE, default 32'h0080_0000; frame base address, channel 1.
REQ-004 Parameter LINE_BYTES, default 7680; byte stride per video line (1920 px x 4 B).
REQ-005 Parameter V_DISP, default 1080; lines per frame.
REQ-006 M_AXI_ACLK  input  1  sole clock; all logic rising-edge.
REQ-007 M_AXI_ARESET  input  1  asynchronous, active-high reset.
REQ-008 req_valid  input  2  per-channel line-burst request; bit n = channel n.
REQ-009 req_frame_start  input  2  qualifies req_valid[n]; request is first line of a frame.
REQ-010 req_ready  output  2  per-channel accept; handshake when req_valid[n] & req_ready[n].
REQ-011 burst_valid  output  1  burst command to read master.
REQ-012 burst_ready  input  1  read master accepts command.
REQ-013 burst_addr  output  ADDR_WIDTH  start byte address of commanded line.
REQ-014 burst_ch  output  1  channel owning current burst; steers read data.
REQ-015 burst_done  input  1  one-cycle pulse; last beat of current burst delivered.
REQ-016 frame_done  output  2  one-cycle pulse per channel when line V_DISP-1 is accepted.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT_DONE; exactly one burst outstanding at any time.
REQ-019 IDLE: req_ready combinational, one-hot or zero, asserted only for the granted channel; zero outside IDLE.
REQ-020 Grant: single valid channel wins; both valid -> channel not granted last (round-robin via last_grant register).
REQ-021 IDLE + handshake -> ISSUE next cycle; burst_valid, burst_addr, burst_ch registered and valid from that cycle.
REQ-022 ISSUE: burst_valid held high, burst_addr/burst_ch stable until burst_ready; handshake -> WAIT_DONE, burst_valid low next cycle.
REQ-023 WAIT_DONE: burst_done -> IDLE and last_grant <= burst_ch; burst_done in IDLE/ISSUE ignored.
REQ-024 Per channel: next_addr[n] (ADDR_WIDTH) and line_cnt[n] (0..V_DISP-1), updated only on that channel's handshake.
REQ-025 Accept with req_frame_start[n]=1: burst_addr <= BASE[n]; next_addr[n] <= BASE[n]+LINE_BYTES; line_cnt[n] <= 1.
REQ-026 Accept, no frame start, line_cnt[n] < V_DISP-1: burst_addr <= next_addr[n]; next_addr[n] += LINE_BYTES; line_cnt[n] += 1.
REQ-027 Accept, no frame start, line_cnt[n] == V_DISP-1: burst_addr <= next_addr[n]; next_addr[n] <= BASE[n]; line_cnt[n] <= 0; frame_done[n] pulses next cycle.
REQ-028 Address arithmetic modulo 2^ADDR_WIDTH; no overflow flag.
REQ-029 Minimum request-to-request interval: 3 cycles (accept, ISSUE with burst_ready=1, WAIT_DONE with burst_done=1).
REQ-030 req_valid dropped before handshake: no state change, no counter change.

Reset
REQ-031 While M_AXI_ARESET high: state IDLE, req_ready=0, burst_valid=0, burst_addr=0, burst_ch=0, frame_done=0, busy=0.
REQ-032 Reset values: last_grant=1 (channel 0 wins first tie), next_addr[n]=BASE[n], line_cnt[n]=0.
REQ-033 Reset mid-burst abandons burst; no burst_done expected afterwards; first post-reset cycle behaves as IDLE.

Verification
REQ-034 Reset, req_valid=2'b01, frame_start=1, burst_ready=1 -> req_ready=01 one cycle; burst_addr=0x0, burst_ch=0; second ch0 request -> burst_addr=0x1E00.
REQ-035 req_valid=2'b11 held, burst_done 2 cycles after each command -> grants alternate 0,1,0,1; each channel addresses advance by 0x1E00.
REQ-036 1080 ch1 requests, frame_start on first only -> last burst_addr=0x0080_0000+1079*7680; frame_done[1] single pulse; 1081st request addr 0x0080_0000.
REQ-037 burst_ready held low 10 cycles in ISSUE -> burst_valid/addr stable 10 cycles, req_ready=0, busy=1 throughout.
REQ-038 Assert M_AXI_ARESET during WAIT_DONE, release, ch0 request without frame_start -> burst_addr=CH0_BASE; stray burst_done in IDLE ignored.
REQ-039 burst_done pulse during ISSUE -> ignored; FSM still waits burst_ready then a fresh burst_done.
